// File: rtl/aes_sys_pkg.sv
// aes_sys_pkg: shared AES widths, controller state encoding, result record and channel-index width helper
package aes_sys_pkg;
  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 128;
  localparam int CH_W_MAX = 3;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, STORE} state_e;
  typedef struct packed {
    logic [AES_BLK_W-1:0] data;
    logic [CH_W_MAX-1:0]  ch;
    logic                 err;
  } result_t;
  function automatic int ch_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/aes_result_fifo.sv
// aes_result_fifo: first-word-fall-through result queue (push_i/data_i in, pop_i/data_o out, full_o/empty_o/count_o status; data_o zero when empty)
module aes_result_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          wr, rd;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign rd      = pop_i && !empty_o;
  assign wr      = push_i && (!full_o || rd);
  assign data_o  = empty_o ? '0 : mem_q[rd_q];
  assign count_o = cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (rd) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/aes_batch_ctrl.sv
// aes_batch_ctrl: round-robin arbiter of NUM_CH plaintext/key jobs onto one AES core (core_*), run timeout, tagged result FIFO (out_*), done/err counters
module aes_batch_ctrl
  import aes_sys_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int BLK_W = AES_BLK_W,
  parameter int KEY_W = AES_KEY_W,
  parameter int RES_DEPTH = 4,
  parameter int TIMEOUT = 64,
  localparam int CW = ch_w(NUM_CH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  input  logic [NUM_CH*BLK_W-1:0]   in_data,
  input  logic [NUM_CH*KEY_W-1:0]   in_key,
  output logic                      core_rst,
  output logic [BLK_W-1:0]          core_data,
  output logic [KEY_W-1:0]          core_key,
  input  logic [BLK_W-1:0]          core_dout,
  input  logic                      core_done,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BLK_W-1:0]          out_data,
  output logic [CW-1:0]             out_ch,
  output logic                      out_err,
  output logic [15:0]               jobs_done,
  output logic [15:0]               jobs_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = BLK_W + CW + 1;
  state_e                     state_q;
  logic [CW-1:0]              ptr_q, ch_q, win;
  logic [TW-1:0]              timer_q;
  logic [BLK_W-1:0]           res_q;
  logic                       err_q, found, accept, pop, push_ok, full, empty;
  logic [RW-1:0]              fifo_dout;
  logic [$clog2(RES_DEPTH):0] res_cnt_unused;
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (in_valid[(int'(ptr_q) + i) % NUM_CH]) begin
        win   = CW'((int'(ptr_q) + i) % NUM_CH);
        found = 1'b1;
      end
    end
  end
  assign in_ready  = (state_q == IDLE && !reset && found) ? (NUM_CH'(1) << win) : '0;
  assign accept    = |in_ready;
  assign core_rst  = reset || state_q == LOAD;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push_ok   = state_q == STORE && (!full || pop);
  assign {out_data, out_ch, out_err} = fifo_dout;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      ch_q      <= '0;
      core_data <= '0;
      core_key  <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      timer_q   <= '0;
      jobs_done <= '0;
      jobs_err  <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          core_data <= in_data[win*BLK_W +: BLK_W];
          core_key  <= in_key[win*KEY_W +: KEY_W];
          ch_q      <= win;
          ptr_q     <= win == CW'(NUM_CH - 1) ? '0 : win + 1'b1;
          state_q   <= LOAD;
        end
        LOAD: begin
          timer_q <= '0;
          state_q <= RUN;
        end
        RUN: begin
          timer_q <= timer_q + 1'b1;
          if (core_done || timer_q == TW'(TIMEOUT - 1)) begin
            res_q   <= core_done ? core_dout : '0;
            err_q   <= !core_done;
            state_q <= STORE;
          end
        end
        default: if (push_ok) begin
          jobs_done <= jobs_done + 16'(!err_q && jobs_done != 16'hFFFF);
          jobs_err  <= jobs_err + 16'(err_q && jobs_err != 16'hFFFF);
          state_q   <= IDLE;
        end
      endcase
    end
  end
  aes_result_fifo #(.W(RW), .DEPTH(RES_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push_ok),
    .data_i  ({res_q, ch_q, err_q}),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (full),
    .empty_o (empty),
    .count_o (res_cnt_unused)
  );
endmodule

// File: doc/aes_batch_ctrl.md
# aes_batch_ctrl

Multi-channel job controller for the AES datapath. Accepts plaintext/key jobs from NUM_CH independent requesters, grants them round-robin to one shared AES core, supervises each run with a timeout, and queues tagged results in an output FIFO. Sits between the debug/host request sources and the AES core, replacing a direct single-source core hookup with a managed, multi-source path.

## Interface
- NUM_CH, 4, number of request channels (1..8)
- BLK_W, 128, plaintext/ciphertext width
- KEY_W, 128, key width
- RES_DEPTH, 4, result FIFO depth (power of 2, >=2)
- TIMEOUT, 64, max RUN cycles before abort (>=2)
- clk  in  1  sole clock; everything is on its rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  NUM_CH  per-channel job valid
- in_ready  out  NUM_CH  per-channel accept
- in_data  in  NUM_CH*BLK_W  channel i at [i*BLK_W +: BLK_W]
- in_key  in  NUM_CH*KEY_W  channel i at [i*KEY_W +: KEY_W]
- core_rst  out  1  restart pulse to the AES core
- core_data  out  BLK_W  core plaintext, registered
- core_key  out  KEY_W  core key, registered
- core_dout  in  BLK_W  core ciphertext
- core_done  in  1  core completion flag ("sure")
- out_valid / out_ready  out / in  1 / 1  result handshake
- out_data  out  BLK_W  ciphertext, zero on error
- out_ch  out  $clog2(NUM_CH) (min 1)  originating channel
- out_err  out  1  1 = timed out
- jobs_done, jobs_err  out  16 / 16  saturating counters

## Operation
- FSM: IDLE, LOAD, RUN, STORE.
- IDLE: round-robin arbiter picks the first asserted in_valid at or after grant pointer `ptr`. in_ready is one-hot on the winner, combinational, IDLE only. On handshake: latch data/key into core_data/core_key, latch channel, ptr <= winner+1 (mod NUM_CH), go LOAD.
- LOAD: one cycle, core_rst=1, go RUN, clear timer.
- RUN: timer increments each cycle. core_done=1: capture core_dout, err=0, go STORE. Otherwise timer==TIMEOUT-1: err=1, data=0, go STORE. Both in same cycle: done wins.
- STORE: push {data, ch, err} when FIFO not full, or full with a pop in the same cycle; then IDLE. Otherwise hold in STORE, no new accepts.
- jobs_done increments per push with err=0; jobs_err per push with err=1; both saturate at 16'hFFFF.
- core_rst = reset OR (state==LOAD).

## Timing
- Reset: state IDLE, ptr 0, FIFO empty, out_valid 0, out_data/out_ch/out_err 0, core_data/core_key 0, counters 0, in_ready 0, core_rst 1.
- Reset mid-job: job dropped, nothing pushed, FIFO contents lost.
- Accept at cycle T -> core_rst high T+1 -> RUN from T+2. Done seen at T+2+k -> STORE T+3+k -> out_valid T+4+k (FIFO output registered, empty FIFO).
- Timeout: err result pushed at T+2+TIMEOUT (STORE cycle), visible next cycle.
- Next accept no earlier than the cycle after STORE completes.
- FIFO: first-word-fall-through registered output; out_valid held until out_ready; out_* stable while out_valid && !out_ready.
- core_done outside RUN is ignored.

## Structure
- Package aes_sys_pkg: AES_BLK_W=128, AES_KEY_W=128, state enum (IDLE/LOAD/RUN/STORE), result struct {data, ch, err}.
- Sub-module aes_result_fifo (parametrised width/depth, push/pop/full/empty, count). Arbiter, FSM, timer, counters stay in aes_batch_ctrl.

## Test plan
- Single job ch2, key 000102..0F, data 00112233..FF, core model done after 10 cycles -> out_data = 69C4E0D8..C55A, out_ch=2, out_err=0, out_valid at accept+14.
- All 4 channels valid continuously, ptr from 0 -> grants 0,1,2,3,0; no channel starved; jobs_done=5.
- Core never raises done, TIMEOUT=64 -> out_err=1, out_data=0, jobs_err=1, FSM back in IDLE.
- out_ready=0, RES_DEPTH=4, 5 jobs -> 4 queued, FSM held in STORE, in_ready all 0; release out_ready -> 5 results in order.
- core_done on exactly RUN cycle TIMEOUT-1 -> out_err=0, ciphertext captured.
- reset asserted during RUN -> next cycle all outputs at reset values, no result emitted, fresh job completes normally.
